// File: rtl/nlp_uop_executor.sv
// nlp_uop_executor: register file, ALU operand/write-back and req/ack memory bus for decoder micro-ops
module nlp_uop_executor #(
  parameter logic [15:0] SP_RESET = 16'h0000,
  parameter logic [15:0] IP_RESET = 16'h0000,
  parameter int          TIMEOUT  = 255
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_uop_valid,
  output logic        o_uop_ready,
  input  logic [5:0]  i_alu_op,
  input  logic [3:0]  i_s1,
  input  logic [3:0]  i_s2,
  input  logic [3:0]  i_dest,
  input  logic        i_mem_rd,
  input  logic        i_mem_wr,
  output logic [5:0]  o_alu_op,
  output logic [15:0] o_alu_a,
  output logic [15:0] o_alu_b,
  input  logic [15:0] i_alu_y,
  input  logic [15:0] i_alu_flags,
  output logic        o_mem_req,
  output logic        o_mem_we,
  output logic [15:0] o_mem_addr,
  output logic [15:0] o_mem_wdata,
  input  logic        i_mem_ack,
  input  logic [15:0] i_mem_rdata,
  output logic [15:0] o_ir1,
  output logic [15:0] o_ir2,
  output logic [15:0] o_ir3,
  output logic [15:0] o_ip,
  output logic [15:0] o_sp,
  output logic [15:0] o_flags,
  output logic        o_err
);
  typedef enum logic {IDLE, MEM} state_t;
  state_t      state_q, state_d;
  logic [15:0] regs [16];
  logic [7:0]  cnt_q;
  logic        we_q;
  logic [3:0]  dest_q;
  logic [15:0] addr_q, wdata_q;
  logic        acc, alu_wr, mem_acc, ill, flag_wr, tmo, rd_wr;
  always_comb begin
    acc     = state_q == IDLE && i_uop_valid;
    alu_wr  = acc && !i_mem_rd && !i_mem_wr;
    mem_acc = acc && (i_mem_rd ^ i_mem_wr);
    ill     = acc && i_mem_rd && i_mem_wr;
    flag_wr = alu_wr && i_alu_op != 6'h00 && i_dest != 4'd2;
    tmo     = state_q == MEM && !i_mem_ack && cnt_q == 8'(TIMEOUT - 1);
    rd_wr   = state_q == MEM && i_mem_ack && !we_q;
    state_d = mem_acc ? MEM : (state_q == MEM && (i_mem_ack || tmo)) ? IDLE : state_q;
  end
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      o_err   <= 1'b0;
      we_q    <= 1'b0;
      dest_q  <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= (state_q == MEM && !i_mem_ack && !tmo) ? cnt_q + 8'd1 : 8'd0;
      if (ill || tmo) o_err <= 1'b1;
      if (mem_acc) begin
        addr_q  <= i_s2 == 4'd15 ? regs[13] : regs[i_s2];
        wdata_q <= regs[i_s1];
        we_q    <= i_mem_wr;
        dest_q  <= i_dest;
      end
    end
  end
  // r15 is reset to zero and never written, so it reads as ZR on every port
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 16; i++)
        regs[i] <= i == 13 ? IP_RESET : i == 14 ? SP_RESET : 16'h0000;
    end else begin
      if (flag_wr) regs[2] <= i_alu_flags;
      if (alu_wr && i_dest != 4'd15) regs[i_dest] <= i_alu_y;
      if (rd_wr && dest_q != 4'd15) regs[dest_q] <= i_mem_rdata;
    end
  end
  assign o_uop_ready = state_q == IDLE;
  assign o_alu_op    = i_alu_op;
  assign o_alu_a     = regs[i_s1];
  assign o_alu_b     = regs[i_s2];
  assign o_mem_req   = state_q == MEM;
  assign o_mem_we    = o_mem_req && we_q;
  assign o_mem_addr  = addr_q;
  assign o_mem_wdata = wdata_q;
  assign o_ir1       = regs[1];
  assign o_ir2       = regs[0];
  assign o_ir3       = regs[3];
  assign o_flags     = regs[2];
  assign o_ip        = regs[13];
  assign o_sp        = regs[14];
endmodule

// File: doc/nlp_uop_executor.md
Name: nlp_uop_executor

Overview:
- Consumer end of the NLP-16AF decoder micro-op interface (alu_op, s1, s2, dest, mem_rd, mem_wr).
- Owns the 16x16 register file, including IR1/IR2/IR3, FLAG, IP, SP and ZR.
- Drives operands to the external ALU and writes back its result.
- Runs a req/ack memory bus for memory micro-ops, and stalls the decoder through o_uop_ready while a bus cycle is outstanding.

Parameters:
- SP_RESET, 16'h0000, reset value of SP (r14); the first push lands at 16'hFFFF.
- IP_RESET, 16'h0000, reset value of IP (r13).
- TIMEOUT, 255, maximum cycles o_mem_req may stay high without i_mem_ack; range 1..255 (8-bit counter).

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  asynchronous active-low reset
- i_uop_valid  in  1  micro-op present this cycle
- o_uop_ready  out  1  micro-op accepted this cycle (decoder advances only when valid&ready)
- i_alu_op  in  6  ALU opcode; passed to ALU
- i_s1  in  4  source1 register index
- i_s2  in  4  source2 register index; memory address select
- i_dest  in  4  destination register index
- i_mem_rd  in  1  memory read micro-op
- i_mem_wr  in  1  memory write micro-op
- o_alu_op  out  6  = i_alu_op
- o_alu_a  out  16  reg[i_s1]
- o_alu_b  out  16  reg[i_s2]
- i_alu_y  in  16  ALU result (combinational)
- i_alu_flags  in  16  ALU flag word
- o_mem_req  out  1  bus request
- o_mem_we  out  1  1=write
- o_mem_addr  out  16  bus address
- o_mem_wdata  out  16  write data
- i_mem_ack  in  1  bus completion
- i_mem_rdata  in  16  read data, valid with ack
- o_ir1, o_ir2, o_ir3  out  16 each  r1, r0, r3 to decoder
- o_ip, o_sp, o_flags  out  16 each  r13, r14, r2
- o_err  out  1  sticky bus-timeout / illegal micro-op error

Behaviour:
Register map:
- r0=IR2, r1=IR1, r2=FLAG, r3=IR3, r13=IP, r14=SP, r15=ZR; others general purpose.
- ZR reads 0 on every port; writes to ZR are discarded.

Reset (asynchronous):
- All registers 0, except IP=IP_RESET and SP=SP_RESET.
- FSM=IDLE, timeout counter=0, o_err=0, o_mem_req=0, o_mem_we=0.
- o_mem_addr=0 and o_mem_wdata=0.

FSM has two states, IDLE and MEM.

IDLE state:
- o_uop_ready=1.
- ALU micro-op (valid, mem_rd=0, mem_wr=0):
  - Single cycle. At the edge, reg[dest] <= i_alu_y.
  - If alu_op != 6'h00 and dest != FLAG, FLAG <= i_alu_flags on the same edge.
  - dest==FLAG: the ALU result wins and flags are not written.
- Memory micro-op (valid, exactly one of rd/wr):
  - Accepted this cycle.
  - Latch addr = (s2==ZR) ? IP : reg[s2], wdata = reg[s1], dest, and we = mem_wr.
  - Next state is MEM. No register write at acceptance.
- mem_rd=1 and mem_wr=1 together:
  - Accepted, no register or bus effect, o_err <= 1.
- valid=0: nothing changes.

MEM state:
- o_uop_ready=0.
- o_mem_req=1, with the latched addr/wdata/we held stable until ack.
- Request is first visible the cycle after acceptance.
- On i_mem_ack:
  - If read, reg[dest] <= i_mem_rdata.
  - Return to IDLE the next cycle; req drops at that edge.
- Ack arriving in the same cycle as req first rises is legal (single-cycle bus).
- The counter increments each MEM cycle without ack. When it reaches TIMEOUT:
  - o_err <= 1, return to IDLE, no write-back.
  - The micro-op counts as complete, so the decoder is not re-stalled.
- i_mem_ack outside MEM is ignored.

Other rules:
- Operand read is combinational from current register contents, so a write is visible to the next micro-op.
- Reset mid-MEM drops req immediately (async) and writes nothing.
- o_err is cleared only by reset.

Test Plan:
- Reset → IP=IP_RESET, SP=SP_RESET, o_err=0, o_mem_req=0, o_uop_ready=1; reading r15 returns 0.
- ALU uop with s1=IP, dest=IP, alu_op=6'h1B, bench ALU y=a+1 and flags=16'h0004 → IP 0→1 in one cycle, FLAG=16'h0004; with dest=FLAG → FLAG=y.
- Fetch uop (mem_rd, s2=ZR, dest=IR1) with IP=16'h0010, ack after 3 cycles, rdata=16'hA5C3 → addr=16'h0010, ready low 4 cycles, o_ir1=16'hA5C3.
- Push pair: SP dec (SP 0→16'hFFFF), then mem_wr with s1=r4=16'h1234, s2=SP → we=1, addr=16'hFFFF, wdata=16'h1234; no register changes.
- No ack, TIMEOUT=4 → req high exactly 4 cycles, o_err=1 sticky, dest unchanged, ready returns to 1.
- mem_rd&mem_wr together → o_err=1, no req. Separately, write dest=ZR → r15 still reads 0.
